// File: rtl/id_stage_pipe_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mips_dec_pkg
// Purpose  : Shared decode constants for the MIPS ID stage: opcode, funct and
//            REGIMM rt codes, ALU operation codes and the control bundle type.
// Ports    : none (package)
// Revision : 1.0  initial release
// ============================================================================
package mips_dec_pkg;

  // Primary opcodes (instr[31:26])
  localparam logic [5:0] OP_RTYPE  = 6'h00;
  localparam logic [5:0] OP_REGIMM = 6'h01;
  localparam logic [5:0] OP_J      = 6'h02;
  localparam logic [5:0] OP_BEQ    = 6'h04;
  localparam logic [5:0] OP_BNE    = 6'h05;
  localparam logic [5:0] OP_BLEZ   = 6'h06;
  localparam logic [5:0] OP_BGTZ   = 6'h07;
  localparam logic [5:0] OP_ADDI   = 6'h08;
  localparam logic [5:0] OP_ADDIU  = 6'h09;
  localparam logic [5:0] OP_SLTI   = 6'h0A;
  localparam logic [5:0] OP_SLTIU  = 6'h0B;
  localparam logic [5:0] OP_ANDI   = 6'h0C;
  localparam logic [5:0] OP_ORI    = 6'h0D;
  localparam logic [5:0] OP_XORI   = 6'h0E;
  localparam logic [5:0] OP_LW     = 6'h23;
  localparam logic [5:0] OP_SW     = 6'h2B;

  // R-type funct codes (instr[5:0])
  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_SRA  = 6'h03;
  localparam logic [5:0] FN_SLLV = 6'h04;
  localparam logic [5:0] FN_SRLV = 6'h06;
  localparam logic [5:0] FN_SRAV = 6'h07;
  localparam logic [5:0] FN_JR   = 6'h08;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_XOR  = 6'h26;
  localparam logic [5:0] FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLT  = 6'h2A;
  localparam logic [5:0] FN_SLTU = 6'h2B;

  // REGIMM branch selectors (instr[20:16])
  localparam logic [4:0] RT_BLTZ = 5'h00;
  localparam logic [4:0] RT_BGEZ = 5'h01;

  // ALU operation codes
  localparam logic [4:0] ALU_ADD  = 5'd0;
  localparam logic [4:0] ALU_AND  = 5'd1;
  localparam logic [4:0] ALU_XOR  = 5'd2;
  localparam logic [4:0] ALU_OR   = 5'd3;
  localparam logic [4:0] ALU_NOR  = 5'd4;
  localparam logic [4:0] ALU_SUB  = 5'd5;
  localparam logic [4:0] ALU_ANDI = 5'd6;
  localparam logic [4:0] ALU_XORI = 5'd7;
  localparam logic [4:0] ALU_ORI  = 5'd8;
  localparam logic [4:0] ALU_JR   = 5'd9;
  localparam logic [4:0] ALU_BEQ  = 5'd10;
  localparam logic [4:0] ALU_BNE  = 5'd11;
  localparam logic [4:0] ALU_BGEZ = 5'd12;
  localparam logic [4:0] ALU_BGTZ = 5'd13;
  localparam logic [4:0] ALU_BLEZ = 5'd14;
  localparam logic [4:0] ALU_BLTZ = 5'd15;
  localparam logic [4:0] ALU_SLL  = 5'd16;
  localparam logic [4:0] ALU_SRL  = 5'd17;
  localparam logic [4:0] ALU_SRA  = 5'd18;
  localparam logic [4:0] ALU_SLT  = 5'd19;
  localparam logic [4:0] ALU_SLTU = 5'd20;

  typedef struct packed {
    logic reg_write;
    logic mem_read;
    logic mem_write;
    logic mem_to_reg;
    logic reg_dst;
    logic alu_src_a;
    logic alu_src_b;
    logic j;
    logic jr;
    logic branch;
  } ctrl_t;

  // Logical immediates are zero-extended; everything else sign-extends.
  function automatic logic is_zext_op(input logic [5:0] op);
    return (op == OP_ANDI) || (op == OP_ORI) || (op == OP_XORI);
  endfunction

endpackage
`default_nettype wire

// File: rtl/id_stage_pipe_if.sv
`default_nettype none
// ============================================================================
// Module   : id_stage_pipe_if
// Purpose  : Fetch-side and execute-side signals of the ID stage.
// Ports    : master = fetch/execute environment, slave = ID stage.
//            in_valid/in_instr/in_ready  fetch handshake
//            flush                       taken branch/jump kill
//            out_ready/out_valid/out_*   ID/EX register and handshake
//            stall_cnt/flush_cnt         event counters
// Revision : 1.0  initial release
// ============================================================================
interface id_stage_pipe_if #(
  parameter int DATA_W = 32,
  parameter int RA_W   = 5,
  parameter int ALU_W  = 5,
  parameter int CNT_W  = 16
);
  logic              in_valid;
  logic [DATA_W-1:0] in_instr;
  logic              in_ready;
  logic              flush;
  logic              out_ready;
  logic              out_valid;
  logic [ALU_W-1:0]  out_alu_code;
  logic              out_reg_write;
  logic              out_mem_read;
  logic              out_mem_write;
  logic              out_mem_to_reg;
  logic              out_reg_dst;
  logic              out_alu_src_a;
  logic              out_alu_src_b;
  logic              out_j;
  logic              out_jr;
  logic              out_branch;
  logic [RA_W-1:0]   out_rs;
  logic [RA_W-1:0]   out_rt;
  logic [RA_W-1:0]   out_wa;
  logic [DATA_W-1:0] out_imm;
  logic [4:0]        out_shamt;
  logic              out_illegal;
  logic [CNT_W-1:0]  stall_cnt;
  logic [CNT_W-1:0]  flush_cnt;

  modport master (
    output in_valid, in_instr, flush, out_ready,
    input  in_ready, out_valid, out_alu_code, out_reg_write, out_mem_read,
           out_mem_write, out_mem_to_reg, out_reg_dst, out_alu_src_a,
           out_alu_src_b, out_j, out_jr, out_branch, out_rs, out_rt, out_wa,
           out_imm, out_shamt, out_illegal, stall_cnt, flush_cnt
  );

  modport slave (
    input  in_valid, in_instr, flush, out_ready,
    output in_ready, out_valid, out_alu_code, out_reg_write, out_mem_read,
           out_mem_write, out_mem_to_reg, out_reg_dst, out_alu_src_a,
           out_alu_src_b, out_j, out_jr, out_branch, out_rs, out_rt, out_wa,
           out_imm, out_shamt, out_illegal, stall_cnt, flush_cnt
  );
endinterface
`default_nettype wire

// File: rtl/id_stage_pipe_decoder.sv
`default_nettype none
// ============================================================================
// Module   : instr_decoder
// Purpose  : Purely combinational MIPS instruction decode.
// Ports    : instr_i     instruction word
//            ctrl_o      control bundle (zero for NOP and illegal words)
//            alu_code_o  ALU operation code
//            illegal_o   unrecognised encoding
//            reads_rt_o  instruction consumes rt as a source operand
//            rs_o/rt_o/wa_o  source and destination addresses
//            imm_o       extended immediate, shamt_o shift amount
// Revision : 1.0  initial release
// ============================================================================
module instr_decoder
  import mips_dec_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int RA_W   = 5,
  parameter int ALU_W  = 5
) (
  input  logic [DATA_W-1:0] instr_i,
  output ctrl_t             ctrl_o,
  output logic [ALU_W-1:0]  alu_code_o,
  output logic              illegal_o,
  output logic              reads_rt_o,
  output logic [RA_W-1:0]   rs_o,
  output logic [RA_W-1:0]   rt_o,
  output logic [RA_W-1:0]   wa_o,
  output logic [DATA_W-1:0] imm_o,
  output logic [4:0]        shamt_o
);

  logic [5:0] op;
  logic [5:0] fn;
  logic [4:0] rt_f;
  logic       r_alu, sh_c, i_alu, ld, st, jmp, jreg, br, ill;
  logic [4:0] code;

  assign op   = instr_i[31:26];
  assign fn   = instr_i[5:0];
  assign rt_f = instr_i[20:16];

  always_comb begin
    r_alu      = 1'b0;
    sh_c       = 1'b0;
    i_alu      = 1'b0;
    ld         = 1'b0;
    st         = 1'b0;
    jmp        = 1'b0;
    jreg       = 1'b0;
    br         = 1'b0;
    ill        = 1'b0;
    reads_rt_o = 1'b0;
    code       = ALU_ADD;
    case (op)
      OP_RTYPE: begin
        reads_rt_o = 1'b1;
        // The all-zero word is the canonical NOP, not "sll $0,$0,0".
        if (instr_i[31:0] != 32'h0) begin
          case (fn)
            FN_SLL:           begin sh_c  = 1'b1; code = ALU_SLL;  end
            FN_SRL:           begin sh_c  = 1'b1; code = ALU_SRL;  end
            FN_SRA:           begin sh_c  = 1'b1; code = ALU_SRA;  end
            FN_SLLV:          begin r_alu = 1'b1; code = ALU_SLL;  end
            FN_SRLV:          begin r_alu = 1'b1; code = ALU_SRL;  end
            FN_SRAV:          begin r_alu = 1'b1; code = ALU_SRA;  end
            FN_JR:            begin jreg  = 1'b1; code = ALU_JR;   end
            FN_ADD, FN_ADDU:  begin r_alu = 1'b1; code = ALU_ADD;  end
            FN_SUB, FN_SUBU:  begin r_alu = 1'b1; code = ALU_SUB;  end
            FN_AND:           begin r_alu = 1'b1; code = ALU_AND;  end
            FN_OR:            begin r_alu = 1'b1; code = ALU_OR;   end
            FN_XOR:           begin r_alu = 1'b1; code = ALU_XOR;  end
            FN_NOR:           begin r_alu = 1'b1; code = ALU_NOR;  end
            FN_SLT:           begin r_alu = 1'b1; code = ALU_SLT;  end
            FN_SLTU:          begin r_alu = 1'b1; code = ALU_SLTU; end
            default:          ill = 1'b1;
          endcase
        end
      end
      OP_REGIMM: begin
        case (rt_f)
          RT_BLTZ: begin br = 1'b1; code = ALU_BLTZ; end
          RT_BGEZ: begin br = 1'b1; code = ALU_BGEZ; end
          default: ill = 1'b1;
        endcase
      end
      OP_J:     jmp = 1'b1;
      OP_BEQ:   begin br = 1'b1; code = ALU_BEQ; reads_rt_o = 1'b1; end
      OP_BNE:   begin br = 1'b1; code = ALU_BNE; reads_rt_o = 1'b1; end
      // blez/bgtz have no rt operand; a non-zero rt field is malformed.
      OP_BLEZ:  if (rt_f == 5'd0) begin br = 1'b1; code = ALU_BLEZ; end else ill = 1'b1;
      OP_BGTZ:  if (rt_f == 5'd0) begin br = 1'b1; code = ALU_BGTZ; end else ill = 1'b1;
      OP_ADDI, OP_ADDIU: begin i_alu = 1'b1; code = ALU_ADD;  end
      OP_SLTI:  begin i_alu = 1'b1; code = ALU_SLT;  end
      OP_SLTIU: begin i_alu = 1'b1; code = ALU_SLTU; end
      OP_ANDI:  begin i_alu = 1'b1; code = ALU_ANDI; end
      OP_ORI:   begin i_alu = 1'b1; code = ALU_ORI;  end
      OP_XORI:  begin i_alu = 1'b1; code = ALU_XORI; end
      OP_LW:    ld = 1'b1;
      OP_SW:    begin st = 1'b1; reads_rt_o = 1'b1; end
      default:  ill = 1'b1;
    endcase

    ctrl_o = '0;
    if (!ill) begin
      ctrl_o.reg_write  = ld | r_alu | sh_c | i_alu;
      ctrl_o.reg_dst    = r_alu | sh_c;
      ctrl_o.alu_src_a  = sh_c;
      ctrl_o.alu_src_b  = ld | st | i_alu;
      ctrl_o.mem_read   = ld;
      ctrl_o.mem_to_reg = ld;
      ctrl_o.mem_write  = st;
      ctrl_o.j          = jmp;
      ctrl_o.jr         = jreg;
      ctrl_o.branch     = br;
    end else begin
      code = ALU_ADD;
    end
  end

  assign illegal_o  = ill;
  assign alu_code_o = ALU_W'(code);
  assign rs_o       = RA_W'(instr_i[25:21]);
  assign rt_o       = RA_W'(instr_i[20:16]);
  assign wa_o       = ctrl_o.reg_dst ? RA_W'(instr_i[15:11]) : RA_W'(instr_i[20:16]);
  assign shamt_o    = instr_i[10:6];
  assign imm_o      = is_zext_op(op) ? {{(DATA_W-16){1'b0}}, instr_i[15:0]}
                                     : {{(DATA_W-16){instr_i[15]}}, instr_i[15:0]};

endmodule
`default_nettype wire

// File: rtl/id_stage_pipe.sv
`default_nettype none
// ============================================================================
// Module   : id_stage_pipe
// Purpose  : Registered MIPS decode stage between fetch and execute, with
//            valid/ready handshake, load-use bubble insertion, branch flush
//            and saturating stall/flush event counters.
// Ports    : clk, rst_n (asynchronous, active low)
//            bus  id_stage_pipe_if.slave: fetch handshake, flush, ID/EX
//                 register outputs and counters
// Revision : 1.0  initial release
// ============================================================================
module id_stage_pipe
  import mips_dec_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int RA_W      = 5,
  parameter int ALU_W     = 5,
  parameter int HAZARD_EN = 1,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  id_stage_pipe_if.slave   bus
);

  // Decoder outputs
  ctrl_t             dec_ctrl;
  logic [ALU_W-1:0]  dec_code;
  logic              dec_illegal;
  logic              dec_reads_rt;
  logic [RA_W-1:0]   dec_rs, dec_rt, dec_wa;
  logic [DATA_W-1:0] dec_imm;
  logic [4:0]        dec_shamt;

  // ID/EX register
  logic              valid_q, valid_d;
  ctrl_t             ctrl_q, ctrl_d;
  logic [ALU_W-1:0]  code_q, code_d;
  logic              illegal_q, illegal_d;
  logic [RA_W-1:0]   rs_q, rs_d, rt_q, rt_d, wa_q, wa_d;
  logic [DATA_W-1:0] imm_q, imm_d;
  logic [4:0]        shamt_q, shamt_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;

  logic              hazard;
  logic              in_ready;

  instr_decoder #(
    .DATA_W (DATA_W),
    .RA_W   (RA_W),
    .ALU_W  (ALU_W)
  ) u_dec (
    .instr_i    (bus.in_instr),
    .ctrl_o     (dec_ctrl),
    .alu_code_o (dec_code),
    .illegal_o  (dec_illegal),
    .reads_rt_o (dec_reads_rt),
    .rs_o       (dec_rs),
    .rt_o       (dec_rt),
    .wa_o       (dec_wa),
    .imm_o      (dec_imm),
    .shamt_o    (dec_shamt)
  );

  // A load in ID/EX whose target feeds the incoming instruction cannot be
  // forwarded in time; hold the consumer back one cycle.
  generate
    if (HAZARD_EN != 0) begin : g_hazard
      assign hazard = valid_q & ctrl_q.mem_read & (wa_q != '0) & bus.in_valid &
                      ((wa_q == dec_rs) | ((wa_q == dec_rt) & dec_reads_rt));
    end else begin : g_no_hazard
      assign hazard = 1'b0;
    end
  endgenerate

  assign in_ready = (~valid_q | bus.out_ready) & ~hazard & ~bus.flush;

  always_comb begin
    valid_d     = valid_q;
    ctrl_d      = ctrl_q;
    code_d      = code_q;
    illegal_d   = illegal_q;
    rs_d        = rs_q;
    rt_d        = rt_q;
    wa_d        = wa_q;
    imm_d       = imm_q;
    shamt_d     = shamt_q;
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (bus.flush) begin
      valid_d = 1'b0;
      if (flush_cnt_q != '1) flush_cnt_d = flush_cnt_q + CNT_W'(1);
    end else if (valid_q && !bus.out_ready) begin
      // downstream back-pressure: everything holds
    end else if (hazard) begin
      // hazard implies valid_q, so out_ready is high here: issue a bubble
      valid_d = 1'b0;
      if (stall_cnt_q != '1) stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end else if (bus.in_valid) begin
      valid_d   = 1'b1;
      ctrl_d    = dec_ctrl;
      code_d    = dec_code;
      illegal_d = dec_illegal;
      rs_d      = dec_rs;
      rt_d      = dec_rt;
      wa_d      = dec_wa;
      imm_d     = dec_imm;
      shamt_d   = dec_shamt;
    end else begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q     <= 1'b0;
      ctrl_q      <= '0;
      code_q      <= '0;
      illegal_q   <= 1'b0;
      rs_q        <= '0;
      rt_q        <= '0;
      wa_q        <= '0;
      imm_q       <= '0;
      shamt_q     <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      valid_q     <= valid_d;
      ctrl_q      <= ctrl_d;
      code_q      <= code_d;
      illegal_q   <= illegal_d;
      rs_q        <= rs_d;
      rt_q        <= rt_d;
      wa_q        <= wa_d;
      imm_q       <= imm_d;
      shamt_q     <= shamt_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign bus.in_ready       = in_ready;
  assign bus.out_valid      = valid_q;
  assign bus.out_alu_code   = code_q;
  assign bus.out_reg_write  = ctrl_q.reg_write;
  assign bus.out_mem_read   = ctrl_q.mem_read;
  assign bus.out_mem_write  = ctrl_q.mem_write;
  assign bus.out_mem_to_reg = ctrl_q.mem_to_reg;
  assign bus.out_reg_dst    = ctrl_q.reg_dst;
  assign bus.out_alu_src_a  = ctrl_q.alu_src_a;
  assign bus.out_alu_src_b  = ctrl_q.alu_src_b;
  assign bus.out_j          = ctrl_q.j;
  assign bus.out_jr         = ctrl_q.jr;
  assign bus.out_branch     = ctrl_q.branch;
  assign bus.out_rs         = rs_q;
  assign bus.out_rt         = rt_q;
  assign bus.out_wa         = wa_q;
  assign bus.out_imm        = imm_q;
  assign bus.out_shamt      = shamt_q;
  assign bus.out_illegal    = illegal_q;
  assign bus.stall_cnt      = stall_cnt_q;
  assign bus.flush_cnt      = flush_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_id_stage_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_id_stage_pipe
// Purpose  : Self-checking bench for id_stage_pipe: decode vector table plus
//            handshake, load-use, flush, hold and async-reset sequences.
// Revision : 1.0  initial release
// ============================================================================
module tb_id_stage_pipe;

  localparam int DATA_W = 32;
  localparam int RA_W   = 5;
  localparam int ALU_W  = 5;
  localparam int CNT_W  = 16;

  localparam logic [31:0] I_LW5  = 32'h8C250004; // lw  $5,4($1)
  localparam logic [31:0] I_ADD6 = 32'h00A23020; // add $6,$5,$2
  localparam logic [31:0] I_ADD3 = 32'h00221820; // add $3,$1,$2
  localparam logic [31:0] I_ANDI = 32'h3022FFFF; // andi $2,$1,0xFFFF

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  id_stage_pipe_if #(.DATA_W(DATA_W), .RA_W(RA_W), .ALU_W(ALU_W), .CNT_W(CNT_W)) bus ();

  id_stage_pipe #(
    .DATA_W(DATA_W), .RA_W(RA_W), .ALU_W(ALU_W), .HAZARD_EN(1), .CNT_W(CNT_W)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // ctl order: reg_write mem_read mem_write mem_to_reg reg_dst alu_src_a alu_src_b j jr branch
  typedef struct {
    logic [31:0] instr;
    logic [4:0]  code;
    logic [9:0]  ctl;
    logic [4:0]  wa;
    logic [31:0] imm;
    logic [4:0]  shamt;
    logic        ill;
  } vec_t;

  localparam int NV = 17;
  vec_t vecs [NV];

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  function automatic logic [9:0] ctl_now();
    return {bus.out_reg_write, bus.out_mem_read, bus.out_mem_write, bus.out_mem_to_reg,
            bus.out_reg_dst, bus.out_alu_src_a, bus.out_alu_src_b,
            bus.out_j, bus.out_jr, bus.out_branch};
  endfunction

  task automatic apply_vec(input int i);
    @(negedge clk);
    bus.in_valid  = 1'b1;
    bus.in_instr  = vecs[i].instr;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    chk($sformatf("v%0d valid", i),   64'(bus.out_valid),    64'd1);
    chk($sformatf("v%0d code", i),    64'(bus.out_alu_code), 64'(vecs[i].code));
    chk($sformatf("v%0d ctl", i),     64'(ctl_now()),        64'(vecs[i].ctl));
    chk($sformatf("v%0d wa", i),      64'(bus.out_wa),       64'(vecs[i].wa));
    chk($sformatf("v%0d imm", i),     64'(bus.out_imm),      64'(vecs[i].imm));
    chk($sformatf("v%0d shamt", i),   64'(bus.out_shamt),    64'(vecs[i].shamt));
    chk($sformatf("v%0d illegal", i), 64'(bus.out_illegal),  64'(vecs[i].ill));
    @(posedge clk); // drain so the next vector sees an empty ID/EX register
  endtask

  initial begin
    //             instr          code   ctl            wa     imm            sh     ill
    vecs[0]  = '{32'h00221820, 5'd0,  10'b1000100000, 5'd3, 32'h00001820, 5'd0,  1'b0}; // add $3,$1,$2
    vecs[1]  = '{32'h3022FFFF, 5'd6,  10'b1000001000, 5'd2, 32'h0000FFFF, 5'd31, 1'b0}; // andi
    vecs[2]  = '{32'h2022FFFF, 5'd0,  10'b1000001000, 5'd2, 32'hFFFFFFFF, 5'd31, 1'b0}; // addi -1
    vecs[3]  = '{32'h8C250004, 5'd0,  10'b1101001000, 5'd5, 32'h00000004, 5'd0,  1'b0}; // lw
    vecs[4]  = '{32'hAC250008, 5'd0,  10'b0010001000, 5'd5, 32'h00000008, 5'd0,  1'b0}; // sw
    vecs[5]  = '{32'h1C800010, 5'd13, 10'b0000000001, 5'd0, 32'h00000010, 5'd0,  1'b0}; // bgtz $4
    vecs[6]  = '{32'hFC000000, 5'd0,  10'b0000000000, 5'd0, 32'h00000000, 5'd0,  1'b1}; // op 0x3F
    vecs[7]  = '{32'h00000000, 5'd0,  10'b0000000000, 5'd0, 32'h00000000, 5'd0,  1'b0}; // nop
    vecs[8]  = '{32'h00031100, 5'd16, 10'b1000110000, 5'd2, 32'h00001100, 5'd4,  1'b0}; // sll $2,$3,4
    vecs[9]  = '{32'h00C52007, 5'd18, 10'b1000100000, 5'd4, 32'h00002007, 5'd0,  1'b0}; // srav
    vecs[10] = '{32'h03E00008, 5'd9,  10'b0000000010, 5'd0, 32'h00000008, 5'd0,  1'b0}; // jr $31
    vecs[11] = '{32'h08000100, 5'd0,  10'b0000000100, 5'd0, 32'h00000100, 5'd4,  1'b0}; // j
    vecs[12] = '{32'h04600020, 5'd15, 10'b0000000001, 5'd0, 32'h00000020, 5'd0,  1'b0}; // bltz $3
    vecs[13] = '{32'h2C27FFFF, 5'd20, 10'b1000001000, 5'd7, 32'hFFFFFFFF, 5'd31, 1'b0}; // sltiu
    vecs[14] = '{32'h34418000, 5'd8,  10'b1000001000, 5'd1, 32'h00008000, 5'd0,  1'b0}; // ori
    vecs[15] = '{32'h012A4027, 5'd4,  10'b1000100000, 5'd8, 32'h00004027, 5'd0,  1'b0}; // nor
    vecs[16] = '{32'h1C810010, 5'd0,  10'b0000000000, 5'd1, 32'h00000010, 5'd0,  1'b1}; // bgtz rt!=0

    bus.in_valid  = 1'b0;
    bus.in_instr  = '0;
    bus.flush     = 1'b0;
    bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst valid", 64'(bus.out_valid),    64'd0);
    chk("rst code",  64'(bus.out_alu_code), 64'd0);
    chk("rst stall", 64'(bus.stall_cnt),    64'd0);
    chk("rst flush", 64'(bus.flush_cnt),    64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("idle in_ready", 64'(bus.in_ready), 64'd1);

    for (int i = 0; i < NV; i++) apply_vec(i);

    // Load-use: lw $5 then add $6,$5,$2 -> one bubble
    @(negedge clk);
    bus.in_valid = 1'b1; bus.in_instr = I_LW5; bus.out_ready = 1'b1;
    @(posedge clk); #1;
    chk("lu lw valid", 64'(bus.out_valid), 64'd1);
    @(negedge clk);
    bus.in_instr = I_ADD6;
    #1;
    chk("lu in_ready low", 64'(bus.in_ready), 64'd0);
    @(posedge clk); #1;
    chk("lu bubble valid", 64'(bus.out_valid), 64'd0);
    chk("lu stall_cnt",    64'(bus.stall_cnt), 64'd1);
    chk("lu in_ready up",  64'(bus.in_ready),  64'd1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    chk("lu add valid", 64'(bus.out_valid), 64'd1);
    chk("lu add wa",    64'(bus.out_wa),    64'd6);
    chk("lu add code",  64'(bus.out_alu_code), 64'd0);
    @(posedge clk);

    // Flush while a load-use hazard is present: flush wins
    @(negedge clk);
    bus.in_valid = 1'b1; bus.in_instr = I_LW5;
    @(posedge clk); #1;
    @(negedge clk);
    bus.in_instr = I_ADD6; bus.flush = 1'b1;
    #1;
    chk("fl in_ready", 64'(bus.in_ready), 64'd0);
    @(posedge clk); #1;
    bus.flush = 1'b0; bus.in_valid = 1'b0;
    chk("fl valid",     64'(bus.out_valid), 64'd0);
    chk("fl flush_cnt", 64'(bus.flush_cnt), 64'd1);
    chk("fl stall_cnt", 64'(bus.stall_cnt), 64'd1);
    @(posedge clk); #1;
    chk("fl dropped", 64'(bus.out_valid), 64'd0);

    // Back-pressure hold for three cycles
    @(negedge clk);
    bus.in_valid = 1'b1; bus.in_instr = I_ADD3; bus.out_ready = 1'b0;
    @(posedge clk); #1;
    chk("hold load valid", 64'(bus.out_valid), 64'd1);
    bus.in_instr = I_ANDI;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      chk($sformatf("hold%0d valid", k),    64'(bus.out_valid),    64'd1);
      chk($sformatf("hold%0d wa", k),       64'(bus.out_wa),       64'd3);
      chk($sformatf("hold%0d ctl", k),      64'(ctl_now()),        64'(10'b1000100000));
      chk($sformatf("hold%0d imm", k),      64'(bus.out_imm),      64'h1820);
      chk($sformatf("hold%0d in_ready", k), 64'(bus.in_ready),     64'd0);
    end
    @(negedge clk);
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    chk("release wa",   64'(bus.out_wa),       64'd2);
    chk("release code", 64'(bus.out_alu_code), 64'd6);
    chk("release imm",  64'(bus.out_imm),      64'h0000FFFF);
    bus.in_valid = 1'b0; bus.out_ready = 1'b0;

    // Asynchronous reset in the middle of a hold
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst valid", 64'(bus.out_valid), 64'd0);
    chk("arst wa",    64'(bus.out_wa),    64'd0);
    chk("arst stall", 64'(bus.stall_cnt), 64'd0);
    chk("arst flush", 64'(bus.flush_cnt), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/id_stage_pipe.md
Name: id_stage_pipe

Overview:
- Registered instruction-decode pipeline stage for the 32-bit MIPS core. Sits between the fetch and execute stages.
- Decodes R/I/branch/jump/load/store instructions into the control bundle and a 5-bit ALU op code.
- Adds valid/ready handshaking, load-use hazard detection with bubble insertion, and branch flush.
- Adds illegal-op flagging, immediate extension and stall/flush event counters.

Parameters:
- DATA_W, 32, instruction and immediate-extension width.
- RA_W, 5, register address width.
- ALU_W, 5, ALU op code width; must be at least 5.
- HAZARD_EN, 1, enables load-use stall logic; when 0, hazard is forced to 0.
- CNT_W, 16, width of the stall and flush counters.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  fetch presents an instruction.
- in_instr  in  DATA_W  instruction word.
- in_ready  out  1  stage accepts in_instr this cycle.
- flush  in  1  branch/jump resolved taken; kill the younger instructions.
- out_ready  in  1  execute stage can accept.
- out_valid  out  1  ID/EX register holds a live instruction.
- out_alu_code  out  ALU_W  ALU operation.
- out_reg_write, out_mem_read, out_mem_write, out_mem_to_reg, out_reg_dst, out_alu_src_a, out_alu_src_b  out  1 each  control bundle.
- out_j, out_jr, out_branch  out  1 each  jump, jump-register and any-branch.
- out_rs, out_rt, out_wa  out  RA_W each  source addresses and destination address (rd if reg_dst, else rt).
- out_imm  out  DATA_W  extended immediate.
- out_shamt  out  5  shift amount.
- out_illegal  out  1  unrecognised encoding.
- stall_cnt, flush_cnt  out  CNT_W each  event counters.

Behaviour:
- Reset: every output register is 0, including out_valid, both counters and out_alu_code (0 = add).
- Latency: 1 cycle from accepted input to out_valid.
- Hold: if out_valid and not out_ready, every out_* register holds.
- Decode: combinational decode of in_instr, captured into the ID/EX register on accept. Accept = in_valid and in_ready.
- ALU codes: add 0, and 1, xor 2, or 3, nor 4, sub 5, andi 6, xori 7, ori 8, jr 9, beq 10, bne 11, bgez 12, bgtz 13, blez 14, bltz 15, sll 16, srl 17, sra 18, slt 19, sltu 20.
- ALU code mapping:
  - add/addu/addi/addiu/lw/sw use add; sub/subu use sub.
  - sllv/srlv/srav map to sll/srl/sra.
  - slti/sltiu map to slt/sltu.
  - bgtz decodes to 13 (op 000111, rt 0).
- Control rules:
  - reg_write = lw | R-type ALU | shift | I-type ALU.
  - reg_dst = R-type ALU or shift.
  - alu_src_a = constant shifts (sll/srl/sra).
  - alu_src_b = lw | sw | I-type ALU.
  - mem_read = mem_to_reg = lw; mem_write = sw.
- Immediate: zero-extended for andi/ori/xori; sign-extended otherwise.
- All-zero word is a NOP: out_valid=1, all control 0, out_illegal=0.
- Illegal encodings: out_illegal=1, reg_write/mem_write/mem_read/j/jr/branch forced to 0, alu_code 0.
- Hazard (HAZARD_EN=1):
  - hazard = out_valid & out_mem_read & out_wa≠0 & in_valid & (out_wa==rs | (out_wa==rt & instruction reads rt)).
  - "Reads rt" means R-type, beq/bne, sw.
- in_ready = (~out_valid | out_ready) & ~hazard & ~flush.
- Next-cycle priority, highest first:
  1. flush: out_valid←0, input dropped, flush_cnt+1.
  2. hold.
  3. hazard with out_ready: bubble, out_valid←0, stall_cnt+1.
  4. accept: load the register.
  5. otherwise out_valid←0 when out_ready.
- Flush and hazard in the same cycle: flush wins and only flush_cnt increments.
- Counters saturate at all-ones and do not wrap.
- Reset asserted mid-stall or mid-hold clears state immediately, asynchronously.

Decomposition:
- Package mips_dec_pkg holds:
  - opcode and funct constants, rt codes for the regimm branches;
  - ALU code localparams;
  - a packed struct for the control bundle.
- One combinational sub-module, instr_decoder (instruction → control bundle, illegal flag, imm, addresses). The top holds the pipeline register, hazard logic, handshake and counters.

Test Plan:
- add $3,$1,$2 (0x00221820) with out_ready=1 → next cycle out_valid=1, alu_code=0, reg_write=1, reg_dst=1, out_wa=3.
- lw $5,4($1) then add $6,$5,$2 back-to-back → in_ready=0 for 1 cycle, one bubble (out_valid=0), stall_cnt=1, add issues the cycle after.
- andi $2,$1,0xFFFF → out_imm=0x0000FFFF, alu_code=6; addi with 0xFFFF → out_imm=0xFFFFFFFF, alu_code=0.
- flush asserted with in_valid=1 and a hazard present → out_valid=0, flush_cnt=1, stall_cnt unchanged.
- out_ready=0 for 3 cycles with out_valid=1 → all outputs stable and in_ready=0; bgtz $4 (op 000111) → alu_code=13, branch=1.
- opcode 0x3F → out_illegal=1, reg_write=0, mem_write=0; all-zero word → out_illegal=0, all control 0, out_valid=1.
